key_expansion: RTL and testbench
================================

# key_expansion

Producer of the 1408-bit round-key bus consumed by the encryption and decryption key-addition stages. On a start request it captures a 128-bit cipher key and iteratively expands it, one AES-128 round key per clock, into eleven 128-bit round keys. It holds the completed key schedule stable until the next accepted start.

## Interface

- Parameters: none; AES-128 only, with 11 round keys and 10 expansion rounds fixed.
- clk  input  1  system clock; all state updates on its rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- start  input  1  request to expand `cipherKey`; sampled on the rising edge.
- cipherKey  input  128  cipher key.
  - FIPS-197 byte order: `cipherKey[127:120]` is key byte 0.
  - Word w0 = `cipherKey[127:96]`.
- roundKeys  output  1408  registered key schedule.
  - Round k occupies `[128k+127 : 128k]`, k = 0..10.
  - Round 0 = cipher key; round 10 at `[1407:1280]`.
- busy  output  1  high while expansion rounds are in progress.
- keysValid  output  1  high while `roundKeys` holds a complete schedule.

## Operation

- FSM states: IDLE, RUN, DONE; round counter `rnd` is 4 bits.
- IDLE or DONE with `start`=1:
  - Slice 0 <= `cipherKey`; slices 1..10 are not cleared.
  - `rnd` <= 1, `keysValid` <= 0, `busy` <= 1, state -> RUN.
- RUN, each cycle:
  - Slice `rnd` <= NextKey(slice `rnd`-1, Rcon[`rnd`]).
  - `rnd` <= `rnd`+1.
  - When `rnd`==10 is written: state -> DONE, `busy` <= 0, `keysValid` <= 1, `rnd` <= 0.
- NextKey(p, rc), with p = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {rc,24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - Result = {n0,n1,n2,n3}.
- RotWord({a,b,c,d}) = {b,c,d,a}.
- SubWord applies the AES forward S-box to each of its 4 bytes.
  - Implemented locally as a combinational 256-entry lookup, with four parallel instances.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. Indices outside 1..10 yield 00 and are never used.
- All arithmetic is GF(2^8) XOR only; no carries.
- `start` while in RUN is ignored; the expansion in progress completes unchanged.
- `cipherKey` is sampled only on the accepting edge. Later changes have no effect until the next accepted `start`.
- DONE holds all outputs stable indefinitely until a new `start` is accepted.

## Timing

- Reset (`n_rst`=0, asynchronous, any state including mid-RUN):
  - state = IDLE, `rnd` = 0.
  - `roundKeys` = all zeros, `busy` = 0, `keysValid` = 0.
- Edge E0 with `start`=1 (state IDLE or DONE):
  - After E0: slice 0 valid, `busy`=1, `keysValid`=0.
- Edges E1..E10 write slices 1..10 respectively.
- After E10: `keysValid`=1, `busy`=0. Latency from the accepting edge to `keysValid` is 10 cycles.
- `busy` is high for exactly 10 cycles per expansion.
- `start` held high continuously:
  - Accepted at E0, ignored during RUN.
  - Accepted again on the first edge in DONE, which deasserts `keysValid` one cycle after it rose.
- Consumers must treat `roundKeys` as valid only while `keysValid`=1. During RUN, slices above `rnd`-1 hold stale data.
- Reset released mid-cycle: the first active edge after `n_rst` rises behaves as in IDLE.

## Test plan

- **Reset values:** assert `n_rst`=0 for 2 cycles, then release with `start`=0 for 5 cycles.
  - Required: `roundKeys`=0, `busy`=0, `keysValid`=0 throughout.
- **FIPS-197 A.1 key:** pulse `start` with key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: `keysValid` rises exactly 10 cycles after the accepting edge.
  - Slice 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Slice 1 = a0fafe1788542cb123a339392a6c7605.
  - Slice 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- **Zero key:** pulse `start` with key 0.
  - Required: slice 1 = 62636363626363636263636362636363.
  - Slice 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- **Start during RUN:** pulse `start` with key 0; 4 cycles later, pulse `start` with key 2b7e…4f3c.
  - Required: `busy` stays high exactly 10 cycles; final schedule equals the zero-key schedule.
- **Restart from DONE:** after the zero-key schedule completes, pulse `start` with key 2b7e…4f3c.
  - Required: `keysValid` falls the next cycle, `busy`=1, and the A.1 schedule is valid 10 cycles later.
- **Reset mid-operation:** assert `n_rst`=0 during the 5th RUN cycle.
  - Required: outputs go to zero immediately, without waiting for a clock edge.
  - After release, a new `start` produces the correct schedule with 10-cycle latency.

Source files
------------

// File: rtl/key_expansion.sv
// AES-128 key schedule: one round key per clock, 10 cycles from accepted start to keysValid.
// No backpressure: start is ignored while busy; the finished schedule is held until the next start.
module key_expansion (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic [127:0]  cipherKey,
  output logic [1407:0] roundKeys,
  output logic          busy,
  output logic          keysValid
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Forward S-box, byte 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      rnd_q, rnd_d;
  logic [1407:0]   keys_q, keys_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;

  logic [127:0]    prev_key, next_key;
  logic [31:0]     rot_w, sub_w, t_w, n0, n1, n2, n3;

  always_comb begin
    prev_key = '0;
    for (int k = 0; k < 10; k++) begin
      if (rnd_q == 4'(k + 1)) prev_key = keys_q[128*k +: 128];
    end
  end

  always_comb begin
    rot_w    = {prev_key[23:0], prev_key[31:24]};
    sub_w    = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    t_w      = sub_w ^ {rcon(rnd_q), 24'h0};
    n0       = prev_key[127:96] ^ t_w;
    n1       = prev_key[95:64]  ^ n0;
    n2       = prev_key[63:32]  ^ n1;
    n3       = prev_key[31:0]   ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    keys_d  = keys_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          keys_d[127:0] = cipherKey;
          rnd_d         = 4'd1;
          valid_d       = 1'b0;
          busy_d        = 1'b1;
          state_d       = RUN;
        end
      end
      RUN: begin
        for (int k = 1; k <= 10; k++) begin
          if (rnd_q == 4'(k)) keys_d[128*k +: 128] = next_key;
        end
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          rnd_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        rnd_d   = 4'd0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      keys_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      keys_q  <= keys_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign roundKeys = keys_q;
  assign busy      = busy_q;
  assign keysValid = valid_q;

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: reference schedule built from an algebraic S-box, queued per accepted start.
module tb_key_expansion;

  logic          clk;
  logic          n_rst;
  logic          start;
  logic [127:0]  cipherKey;
  logic [1407:0] roundKeys;
  logic          busy;
  logic          keysValid;

  int checks   = 0;
  int failures = 0;

  logic [1407:0] sb [$];
  logic [7:0]    ref_sbox [256];

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_expansion dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .cipherKey (cipherKey),
    .roundKeys (roundKeys),
    .busy      (busy),
    .keysValid (keysValid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic       hi;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y  = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic init_model();
    logic [7:0] inv, xb, yb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = 8'(y);
        if (gmul(xb, yb) == 8'h01) inv = yb;
      end
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] model_expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) r[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return r;
  endfunction

  function automatic int first_bad(input logic [1407:0] a, input logic [1407:0] b);
    for (int k = 0; k < 11; k++) begin
      if (a[128*k +: 128] !== b[128*k +: 128]) return k;
    end
    return -1;
  endfunction

  function automatic logic [1407:0] sb_pop();
    if (sb.size() > 0) return sb.pop_front();
    return 'x;
  endfunction

  // Called at a falling edge; the following rising edge accepts the key.
  task automatic pulse_start(input logic [127:0] key);
    start     = 1'b1;
    cipherKey = key;
    sb.push_back(model_expand(key));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for keysValid, counting cycles and busy samples; optionally re-pulses start mid-run.
  task automatic wait_done(input bit inject, input logic [127:0] ikey, output int cycles, output int bc);
    cycles = 0;
    bc     = (busy === 1'b1) ? 1 : 0;
    while (keysValid !== 1'b1 && cycles < 50) begin
      if (inject && cycles == 3) begin
        start     = 1'b1;
        cipherKey = ikey;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
      if (busy === 1'b1) bc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1; start = 1'b0; cipherKey = '0;
    #2 n_rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 2) n_rst = 1'b1;
      checks++;
      if (roundKeys !== '0 || busy !== 1'b0 || keysValid !== 1'b0) begin
        failures++;
        $display("FAIL reset_vals sample %0d: nonzero_keys=%b busy=%b keysValid=%b, required 0 0 0",
                 i, |roundKeys, busy, keysValid);
      end
    end
  endtask

  task automatic test_fips_a1();
    int cyc, bc, bad;
    logic [1407:0] exp;
    pulse_start(KEY_A1);
    checks++;
    if (busy !== 1'b1 || keysValid !== 1'b0 || roundKeys[127:0] !== KEY_A1) begin
      failures++;
      $display("FAIL a1_accept busy=%b keysValid=%b slice0=%h, required 1 0 %h", busy, keysValid, roundKeys[127:0], KEY_A1);
    end
    wait_done(1'b0, '0, cyc, bc);
    checks++;
    if (cyc !== 10) begin
      failures++;
      $display("FAIL a1_latency got %0d cycles, required 10", cyc);
    end
    checks++;
    if (bc !== 10) begin
      failures++;
      $display("FAIL a1_busy_len got %0d cycles, required 10", bc);
    end
    checks++;
    if (roundKeys[255:128] !== A1_R1) begin
      failures++;
      $display("FAIL a1_slice1 got %h, required %h", roundKeys[255:128], A1_R1);
    end
    checks++;
    if (roundKeys[1407:1280] !== A1_R10) begin
      failures++;
      $display("FAIL a1_slice10 got %h, required %h", roundKeys[1407:1280], A1_R10);
    end
    exp = sb_pop();
    bad = first_bad(roundKeys, exp);
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL a1_schedule slice %0d got %h, required %h", bad, roundKeys[128*bad +: 128], exp[128*bad +: 128]);
    end
  endtask

  task automatic test_zero_key();
    int cyc, bc, bad;
    logic [1407:0] exp;
    pulse_start('0);
    wait_done(1'b0, '0, cyc, bc);
    checks++;
    if (cyc !== 10) begin
      failures++;
      $display("FAIL zero_latency got %0d cycles, required 10", cyc);
    end
    checks++;
    if (roundKeys[255:128] !== Z_R1 || roundKeys[1407:1280] !== Z_R10) begin
      failures++;
      $display("FAIL zero_slices got s1=%h s10=%h, required %h %h", roundKeys[255:128], roundKeys[1407:1280], Z_R1, Z_R10);
    end
    exp = sb_pop();
    bad = first_bad(roundKeys, exp);
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL zero_schedule slice %0d got %h, required %h", bad, roundKeys[128*bad +: 128], exp[128*bad +: 128]);
    end
    // Key input wanders without start: schedule and flags must hold.
    cipherKey = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    bad = first_bad(roundKeys, exp);
    checks++;
    if (bad >= 0 || keysValid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_hold bad_slice=%0d keysValid=%b busy=%b, required -1 1 0", bad, keysValid, busy);
    end
  endtask

  task automatic test_start_during_run();
    int cyc, bc, bad;
    logic [1407:0] exp;
    pulse_start('0);
    wait_done(1'b1, KEY_A1, cyc, bc);
    checks++;
    if (bc !== 10 || cyc !== 10) begin
      failures++;
      $display("FAIL run_ignore_busy busy=%0d latency=%0d, required 10 10", bc, cyc);
    end
    exp = sb_pop();
    bad = first_bad(roundKeys, exp);
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL run_ignore_schedule slice %0d got %h, required %h", bad, roundKeys[128*bad +: 128], exp[128*bad +: 128]);
    end
  endtask

  task automatic test_restart_from_done();
    int cyc, bc, bad;
    logic [1407:0] exp;
    checks++;
    if (keysValid !== 1'b1) begin
      failures++;
      $display("FAIL restart_precond keysValid=%b, required 1", keysValid);
    end
    pulse_start(KEY_A1);
    checks++;
    if (keysValid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_flags keysValid=%b busy=%b, required 0 1", keysValid, busy);
    end
    wait_done(1'b0, '0, cyc, bc);
    checks++;
    if (cyc !== 10) begin
      failures++;
      $display("FAIL restart_latency got %0d cycles, required 10", cyc);
    end
    exp = sb_pop();
    bad = first_bad(roundKeys, exp);
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL restart_schedule slice %0d got %h, required %h", bad, roundKeys[128*bad +: 128], exp[128*bad +: 128]);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc, bc, bad;
    logic [1407:0] exp;
    logic [1407:0] dropped;
    pulse_start({$urandom, $urandom, $urandom, $urandom});
    repeat (4) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (roundKeys !== '0 || busy !== 1'b0 || keysValid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset nonzero_keys=%b busy=%b keysValid=%b, required 0 0 0", |roundKeys, busy, keysValid);
    end
    if (sb.size() > 0) dropped = sb.pop_back();
    @(negedge clk);
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (roundKeys !== '0 || busy !== 1'b0 || keysValid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle nonzero_keys=%b busy=%b keysValid=%b, required 0 0 0", |roundKeys, busy, keysValid);
    end
    pulse_start({$urandom, $urandom, $urandom, $urandom});
    wait_done(1'b0, '0, cyc, bc);
    checks++;
    if (cyc !== 10 || bc !== 10) begin
      failures++;
      $display("FAIL post_reset_latency latency=%0d busy=%0d, required 10 10", cyc, bc);
    end
    exp = sb_pop();
    bad = first_bad(roundKeys, exp);
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL post_reset_schedule slice %0d got %h, required %h", bad, roundKeys[128*bad +: 128], exp[128*bad +: 128]);
    end
  endtask

  initial begin
    init_model();
    test_reset();
    test_fips_a1();
    test_zero_key();
    test_start_during_run();
    test_restart_from_done();
    test_reset_mid_op();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
